// File: rtl/nf10_axis_pkg.sv
// Shared definitions for the NetFPGA rx packer: tuser field layout, meta entry, read FSM states.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package nf10_axis_pkg;

    localparam int TUSER_LEN_LO = 0;
    localparam int TUSER_LEN_W  = 16;
    localparam int TUSER_SRC_LO = 16;
    localparam int TUSER_SRC_W  = 8;
    localparam int TUSER_DST_LO = 24;
    localparam int TUSER_DST_W  = 8;

    // One committed packet: its byte length.
    typedef struct packed {
        logic [TUSER_LEN_W-1:0] len;
    } meta_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_HEAD = 2'd1,
        RD_BODY = 2'd2
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/nf10_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en; rd_dat holds while rd_en is low.
// Backpressure: none; the caller throttles rd_en.
module nf10_sdp_ram
    import nf10_axis_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/nf10_axis_rx_pkt_packer.sv
// Packs a narrow MAC rx stream into wide words in a store-and-forward FIFO, drops bad/overflowing frames.
// Latency: first m_axis_tvalid 3 cycles after the committing tlast beat.
// Backpressure: input never stalls (drops on full); output holds its beat while tvalid & !tready.
module nf10_axis_rx_pkt_packer
    import nf10_axis_pkg::*;
#(
    parameter int         C_S_AXIS_DATA_WIDTH  = 8,
    parameter int         C_M_AXIS_DATA_WIDTH  = 64,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter int         C_DEPTH_WORDS        = 512,
    parameter int         C_META_DEPTH         = 16,
    parameter logic [7:0] C_DEFAULT_SRC_PORT   = 8'h01,
    parameter logic [7:0] C_DEFAULT_DST_PORT   = 8'h00
) (
    input  logic                              axi_aclk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_terr,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       stat_good_pkts,
    output logic [31:0]                       stat_bad_pkts,
    output logic [31:0]                       stat_ovf_pkts
);

    localparam int SB  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int MB  = C_M_AXIS_DATA_WIDTH / 8;
    localparam int AW  = clog2(C_DEPTH_WORDS);
    localparam int MAW = clog2(C_META_DEPTH);

    function automatic logic [15:0] words_of(input logic [15:0] len);
        return 16'((32'(len) + MB - 1) / MB);
    endfunction

    function automatic logic [MB-1:0] strb_of(input logic [15:0] len);
        int r;
        r = int'(len % 16'(MB));
        strb_of = '0;
        for (int i = 0; i < MB; i++) strb_of[i] = (r == 0) || (i < r);
    endfunction

    // ---------------- write side ----------------
    logic                           rdy_q, beat_vld, in_frame, drop_q;
    logic [15:0]                    byte_cnt, byte_nxt;
    logic [C_M_AXIS_DATA_WIDTH-1:0] acc_dat, acc_nxt;
    logic [AW:0]                    wr_ptr, rd_ptr, rd_fetch, pkt_start_ptr, start_eff;
    logic                           word_vld, wr_en, data_full, drop_eff, zero_frame, commit;
    int                             lane, pop, fill;

    meta_t          meta_mem [C_META_DEPTH];
    meta_t          meta_q;
    logic [MAW:0]   meta_wr, meta_rd;
    logic           meta_full, meta_empty, meta_pop;

    assign s_axis_tready = rdy_q;
    assign beat_vld      = s_axis_tvalid & rdy_q;
    assign meta_q        = meta_mem[meta_rd[MAW-1:0]];
    assign meta_empty    = (meta_wr == meta_rd);
    assign meta_full     = (meta_wr[MAW] != meta_rd[MAW]) && (meta_wr[MAW-1:0] == meta_rd[MAW-1:0]);

    always_comb begin
        lane = int'(byte_cnt % 16'(MB));
        pop  = 0;
        for (int i = 0; i < SB; i++) if (s_axis_tstrb[i]) pop++;
        // A fresh word starts from zero so unused tail bytes read back as 0.
        acc_nxt = (lane == 0) ? '0 : acc_dat;
        for (int i = 0; i < SB; i++)
            if (s_axis_tstrb[i] && (lane + i < MB))
                acc_nxt[(lane + i) * 8 +: 8] = s_axis_tdata[i * 8 +: 8];
        fill       = lane + pop;
        byte_nxt   = byte_cnt + 16'(pop);
        word_vld   = beat_vld && ((fill == MB) || (s_axis_tlast && (fill != 0)));
        data_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        drop_eff   = drop_q || (word_vld && data_full);
        wr_en      = word_vld && !drop_eff;
        start_eff  = in_frame ? pkt_start_ptr : wr_ptr;
        zero_frame = (byte_nxt == 16'd0);
        commit     = beat_vld && s_axis_tlast && !zero_frame && !drop_eff && !meta_full && !s_axis_terr;
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            rdy_q          <= 1'b0;
            byte_cnt       <= '0;
            acc_dat        <= '0;
            in_frame       <= 1'b0;
            drop_q         <= 1'b0;
            wr_ptr         <= '0;
            pkt_start_ptr  <= '0;
            meta_wr        <= '0;
            stat_good_pkts <= '0;
            stat_bad_pkts  <= '0;
            stat_ovf_pkts  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (beat_vld) begin
                acc_dat <= acc_nxt;
                if (!in_frame) pkt_start_ptr <= wr_ptr;
                if (s_axis_tlast) begin
                    byte_cnt <= '0;
                    in_frame <= 1'b0;
                    drop_q   <= 1'b0;
                    if (zero_frame) begin
                        wr_ptr <= start_eff;
                    end else if (drop_eff || meta_full) begin
                        wr_ptr        <= start_eff;
                        stat_ovf_pkts <= stat_ovf_pkts + 32'd1;
                    end else if (s_axis_terr) begin
                        wr_ptr        <= start_eff;
                        stat_bad_pkts <= stat_bad_pkts + 32'd1;
                    end else begin
                        wr_ptr         <= wr_ptr + {{AW{1'b0}}, wr_en};
                        meta_wr        <= meta_wr + 1'b1;
                        stat_good_pkts <= stat_good_pkts + 32'd1;
                    end
                end else begin
                    byte_cnt <= byte_nxt;
                    in_frame <= 1'b1;
                    drop_q   <= drop_eff;
                    if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (commit) meta_mem[meta_wr[MAW-1:0]] <= meta_t'(byte_nxt);
    end

    // ---------------- read side ----------------
    rd_state_t                       rd_state, rd_nxt;
    logic [15:0]                     pkt_len, len_nxt, words_rem, rem_nxt, iss_len, ram_len;
    logic                            issue, iss_first, iss_last, slot_free, load_out;
    logic                            ram_vld, ram_first, ram_last;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  ram_dat, m_dat;
    logic [MB-1:0]                   m_strb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] m_user, user_hdr;
    logic                            m_vld, m_last;

    nf10_sdp_ram #(
        .WIDTH (C_M_AXIS_DATA_WIDTH),
        .DEPTH (C_DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (axi_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_dat  (acc_nxt),
        .rd_en   (issue),
        .rd_addr (rd_fetch[AW-1:0]),
        .rd_dat  (ram_dat)
    );

    // RAM output register is a pipeline stage; it frees when its word moves to the output register.
    assign load_out  = ram_vld && (!m_vld || m_axis_tready);
    assign slot_free = !ram_vld || load_out;

    always_comb begin
        rd_nxt    = rd_state;
        meta_pop  = 1'b0;
        issue     = 1'b0;
        iss_first = 1'b0;
        iss_last  = 1'b0;
        iss_len   = pkt_len;
        len_nxt   = pkt_len;
        rem_nxt   = words_rem;
        case (rd_state)
            RD_IDLE: if (!meta_empty) begin
                meta_pop = 1'b1;
                len_nxt  = meta_q.len;
                iss_len  = meta_q.len;
                rem_nxt  = words_of(meta_q.len);
                rd_nxt   = RD_HEAD;
                if (slot_free) begin
                    issue     = 1'b1;
                    iss_first = 1'b1;
                    iss_last  = (rem_nxt == 16'd1);
                    rem_nxt   = rem_nxt - 16'd1;
                    rd_nxt    = iss_last ? RD_IDLE : RD_BODY;
                end
            end
            RD_HEAD, RD_BODY: if (slot_free) begin
                issue     = 1'b1;
                iss_first = (rd_state == RD_HEAD);
                iss_last  = (words_rem == 16'd1);
                rem_nxt   = words_rem - 16'd1;
                rd_nxt    = iss_last ? RD_IDLE : RD_BODY;
            end
            default: rd_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        user_hdr = '0;
        user_hdr[TUSER_LEN_LO +: TUSER_LEN_W] = ram_len;
        user_hdr[TUSER_SRC_LO +: TUSER_SRC_W] = C_DEFAULT_SRC_PORT;
        user_hdr[TUSER_DST_LO +: TUSER_DST_W] = C_DEFAULT_DST_PORT;
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            rd_state  <= RD_IDLE;
            pkt_len   <= '0;
            words_rem <= '0;
            rd_fetch  <= '0;
            rd_ptr    <= '0;
            meta_rd   <= '0;
            ram_vld   <= 1'b0;
            ram_first <= 1'b0;
            ram_last  <= 1'b0;
            ram_len   <= '0;
            m_vld     <= 1'b0;
            m_dat     <= '0;
            m_strb    <= '0;
            m_user    <= '0;
            m_last    <= 1'b0;
        end else begin
            rd_state  <= rd_nxt;
            pkt_len   <= len_nxt;
            words_rem <= rem_nxt;
            if (meta_pop) meta_rd <= meta_rd + 1'b1;
            if (issue) begin
                rd_fetch  <= rd_fetch + 1'b1;
                ram_vld   <= 1'b1;
                ram_first <= iss_first;
                ram_last  <= iss_last;
                ram_len   <= iss_len;
            end else if (load_out) begin
                ram_vld <= 1'b0;
            end
            if (load_out) begin
                m_vld  <= 1'b1;
                m_dat  <= ram_dat;
                m_strb <= ram_last ? strb_of(ram_len) : '1;
                m_user <= ram_first ? user_hdr : '0;
                m_last <= ram_last;
            end else if (m_axis_tready) begin
                m_vld <= 1'b0;
            end
            // Space is released only when the consumer takes the word, not when it is prefetched.
            if (m_vld && m_axis_tready) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign m_axis_tvalid = m_vld;
    assign m_axis_tdata  = m_dat;
    assign m_axis_tstrb  = m_strb;
    assign m_axis_tuser  = m_user;
    assign m_axis_tlast  = m_last;

endmodule

// File: tb/tb_nf10_axis_rx_pkt_packer.sv
// Directed bench for nf10_axis_rx_pkt_packer with a 16-word data FIFO.
// Latency: n/a. Backpressure: m_axis_tready driven high, low or toggling per phase.
module tb_nf10_axis_rx_pkt_packer;

    logic         axi_aclk = 1'b0;
    logic         reset    = 1'b1;
    logic [7:0]   s_axis_tdata  = '0;
    logic [0:0]   s_axis_tstrb  = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast  = 1'b0;
    logic         s_axis_terr   = 1'b0;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;
    logic [31:0]  stat_good_pkts, stat_bad_pkts, stat_ovf_pkts;

    always #5 axi_aclk = ~axi_aclk;

    nf10_axis_rx_pkt_packer #(
        .C_S_AXIS_DATA_WIDTH  (8),
        .C_M_AXIS_DATA_WIDTH  (64),
        .C_M_AXIS_TUSER_WIDTH (128),
        .C_DEPTH_WORDS        (16),
        .C_META_DEPTH         (16),
        .C_DEFAULT_SRC_PORT   (8'h01),
        .C_DEFAULT_DST_PORT   (8'h00)
    ) dut (
        .axi_aclk       (axi_aclk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_terr    (s_axis_terr),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .stat_good_pkts (stat_good_pkts),
        .stat_bad_pkts  (stat_bad_pkts),
        .stat_ovf_pkts  (stat_ovf_pkts)
    );

    typedef struct packed {
        logic [63:0]  d;
        logic [7:0]   s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        logic       err;
        int         words;
        logic [7:0] lstrb;
        logic [31:0] user;
        int         good;
        int         bad;
        int         ovf;
    } vec_t;

    beat_t got[$];
    beat_t mon_cur, stall_b;
    bit    stall_q = 1'b0;
    int    checks  = 0;
    int    errors  = 0;
    int    rdy_mode = 1;   // 0: low, 1: high, 2: toggle

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge axi_aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ~m_axis_tready;
        endcase
    end

    // Capture handshakes and check that a stalled beat is held unchanged.
    always @(negedge axi_aclk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            mon_cur = '{d: m_axis_tdata, s: m_axis_tstrb, u: m_axis_tuser, l: m_axis_tlast};
            if (stall_q) begin
                chk("stall_vld", 256'(m_axis_tvalid), 256'(1));
                chk("stall_hold", 256'(mon_cur), 256'(stall_b));
            end
            if (m_axis_tvalid && m_axis_tready) got.push_back(mon_cur);
            stall_q = m_axis_tvalid && !m_axis_tready;
            stall_b = mon_cur;
        end
    end

    task automatic beat(input logic [7:0] d, input logic st, input logic last, input logic err);
        @(posedge axi_aclk); #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tstrb  = st;
        s_axis_tlast  = last;
        s_axis_terr   = err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge axi_aclk); #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_terr   = 1'b0;
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic err);
        if (len == 0) beat(8'h00, 1'b0, 1'b1, err);
        else for (int b = 0; b < len; b++) beat(8'(base + b), 1'b1, b == len - 1, err && (b == len - 1));
    endtask

    function automatic logic [63:0] exp_dat(input logic [7:0] base, input int len, input int w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) if (w * 8 + k < len) r[k * 8 +: 8] = 8'(base + w * 8 + k);
        return r;
    endfunction

    task automatic check_pkt(input string tag, input int start, input int len, input logic [7:0] base,
                             input int nw, input logic [7:0] lstrb, input logic [31:0] user);
        beat_t b;
        chk({tag, "_present"}, 256'(got.size() >= start + nw), 256'(1));
        if (got.size() >= start + nw) begin
            for (int w = 0; w < nw; w++) begin
                b = got[start + w];
                chk($sformatf("%s_dat%0d", tag, w), 256'(b.d), 256'(exp_dat(base, len, w)));
                chk($sformatf("%s_strb%0d", tag, w), 256'(b.s), 256'((w == nw - 1) ? lstrb : 8'hFF));
                chk($sformatf("%s_last%0d", tag, w), 256'(b.l), 256'(w == nw - 1));
                chk($sformatf("%s_user%0d", tag, w), 256'(b.u), (w == 0) ? 256'(user) : 256'(0));
            end
        end
    endtask

    task automatic chk_stats(input string tag, input int good, input int bad, input int ovf);
        chk({tag, "_good"}, 256'(stat_good_pkts), 256'(good));
        chk({tag, "_bad"},  256'(stat_bad_pkts),  256'(bad));
        chk({tag, "_ovf"},  256'(stat_ovf_pkts),  256'(ovf));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   n;
        vecs[0] = '{64, 8'h00, 1'b0, 8, 8'hFF, 32'h0001_0040, 1, 0, 0};
        vecs[1] = '{61, 8'h40, 1'b0, 8, 8'h1F, 32'h0001_003D, 2, 0, 0};
        vecs[2] = '{64, 8'h10, 1'b1, 0, 8'hFF, 32'h0000_0000, 2, 1, 0};
        vecs[3] = '{60, 8'h80, 1'b0, 8, 8'h0F, 32'h0001_003C, 3, 1, 0};
        vecs[4] = '{ 1, 8'hA5, 1'b0, 1, 8'h01, 32'h0001_0001, 4, 1, 0};
        vecs[5] = '{ 8, 8'hC0, 1'b0, 1, 8'hFF, 32'h0001_0008, 5, 1, 0};
        vecs[6] = '{ 9, 8'hD0, 1'b0, 2, 8'h01, 32'h0001_0009, 6, 1, 0};
        vecs[7] = '{ 0, 8'h00, 1'b0, 0, 8'hFF, 32'h0000_0000, 6, 1, 0};

        // Reset state
        rdy_mode = 1;
        repeat (3) @(negedge axi_aclk);
        chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_m_tdata",  256'(m_axis_tdata),  256'(0));
        chk("rst_m_tuser",  256'(m_axis_tuser),  256'(0));
        chk_stats("rst", 0, 0, 0);
        @(posedge axi_aclk); #1;
        reset = 1'b0;
        idle(3);
        chk("s_tready_after_rst", 256'(s_axis_tready), 256'(1));

        // Table of single frames with tready held high
        for (int v = 0; v < 8; v++) begin
            got.delete();
            send_frame(vecs[v].len, vecs[v].base, vecs[v].err);
            idle(30);
            chk($sformatf("v%0d_words", v), 256'(got.size()), 256'(vecs[v].words));
            if (vecs[v].words > 0)
                check_pkt($sformatf("v%0d", v), 0, vecs[v].len, vecs[v].base, vecs[v].words,
                          vecs[v].lstrb, vecs[v].user);
            if (v == 0 && got.size() > 0)
                chk("v0_word0_literal", 256'(got[0].d), 256'(64'h0706050403020100));
            chk_stats($sformatf("v%0d", v), vecs[v].good, vecs[v].bad, vecs[v].ovf);
        end

        // Latency: tvalid appears in the third cycle after the tlast cycle
        got.delete();
        send_frame(8, 8'h33, 1'b0);
        idle(1);
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(posedge axi_aclk); #1;
            n++;
        end
        chk("latency_edges", 256'(n), 256'(2));
        idle(10);
        check_pkt("lat", 0, 8, 8'h33, 1, 8'hFF, 32'h0001_0008);
        chk_stats("lat", 7, 1, 0);

        // Overflow: 200 bytes into a 16-word FIFO with no drain
        rdy_mode = 0;
        got.delete();
        send_frame(200, 8'h00, 1'b0);
        idle(20);
        chk("ovf_no_output", 256'(got.size()), 256'(0));
        chk("ovf_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk_stats("ovf", 7, 1, 1);
        rdy_mode = 1;
        idle(2);
        send_frame(64, 8'h20, 1'b0);
        idle(30);
        chk("post_ovf_words", 256'(got.size()), 256'(8));
        check_pkt("post_ovf", 0, 64, 8'h20, 8, 8'hFF, 32'h0001_0040);
        chk_stats("post_ovf", 8, 1, 1);

        // Three back-to-back frames against a toggling consumer
        rdy_mode = 2;
        got.delete();
        send_frame(64, 8'h00, 1'b0);
        send_frame(64, 8'h40, 1'b0);
        send_frame(64, 8'h80, 1'b0);
        idle(80);
        chk("b2b_words", 256'(got.size()), 256'(24));
        check_pkt("b2b0", 0,  64, 8'h00, 8, 8'hFF, 32'h0001_0040);
        check_pkt("b2b1", 8,  64, 8'h40, 8, 8'hFF, 32'h0001_0040);
        check_pkt("b2b2", 16, 64, 8'h80, 8, 8'hFF, 32'h0001_0040);
        chk_stats("b2b", 11, 1, 1);

        // Reset in the middle of a frame
        rdy_mode = 1;
        for (int b = 0; b < 30; b++) beat(8'(b), 1'b1, 1'b0, 1'b0);
        @(posedge axi_aclk); #1;
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        #2;
        chk("mid_rst_s_tready", 256'(s_axis_tready), 256'(0));
        chk("mid_rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("mid_rst_m_tdata",  256'(m_axis_tdata),  256'(0));
        chk("mid_rst_m_tlast",  256'(m_axis_tlast),  256'(0));
        chk_stats("mid_rst", 0, 0, 0);
        idle(3);
        reset = 1'b0;
        idle(2);
        got.delete();
        send_frame(64, 8'h55, 1'b0);
        idle(30);
        chk("after_rst_words", 256'(got.size()), 256'(8));
        check_pkt("after_rst", 0, 64, 8'h55, 8, 8'hFF, 32'h0001_0040);
        chk_stats("after_rst", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nf10_axis_rx_pkt_packer.md
Name: nf10_axis_rx_pkt_packer

Overview:
Parametrised successor to the fixed 8-bit MAC-side receive path. It takes a narrow, non-backpressurable MAC-side AXI-Stream and packs it into a wide AXI-Stream in a store-and-forward packet FIFO. Errored and overflowing frames are dropped by rewinding the write pointer. NetFPGA tuser metadata (length, src port, dst port) is inserted on the first output beat, and per-port drop statistics are kept. It sits between the MAC rx logic and the wide datapath, and replaces the separate queue and width-converter pair.

Parameters:
C_S_AXIS_DATA_WIDTH, 8, input width; multiple of 8; divides C_M_AXIS_DATA_WIDTH.
C_M_AXIS_DATA_WIDTH, 64, output width; R = C_M/C_S.
C_M_AXIS_TUSER_WIDTH, 128, output tuser width; at least 32.
C_DEPTH_WORDS, 512, data FIFO depth in output words; power of 2.
C_META_DEPTH, 16, committed-packet FIFO depth; power of 2.
C_DEFAULT_SRC_PORT, 8'h01, tuser[23:16] value.
C_DEFAULT_DST_PORT, 8'h00, tuser[31:24] value.

Ports:
axi_aclk  in  1  sole clock.
reset  in  1  asynchronous, active-high reset.
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  MAC-side data; byte 0 in [7:0].
s_axis_tstrb  in  C_S/8  contiguous from LSB; may be partial only on tlast.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  0 during reset, otherwise constant 1.
s_axis_tlast  in  1  last beat of frame.
s_axis_terr  in  1  bad-frame flag; sampled only on the tlast beat.
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  packed data.
m_axis_tstrb  out  C_M/8  byte enables.
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  metadata; first beat only.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat of packet.
stat_good_pkts  out  32  committed frames; wraps.
stat_bad_pkts  out  32  frames dropped because terr=1; wraps.
stat_ovf_pkts  out  32  frames dropped on data or meta FIFO full; wraps.

Behaviour:
- Reset (async assert, sync release):
  - All pointers, accumulator, byte counter, FSM and statistics go to 0.
  - All outputs are 0, including s_axis_tready.
  - A partially written or partially read packet is discarded.
- Write side, per accepted beat:
  - Bytes are placed little-endian into the accumulator at lane offset = byte_cnt mod (C_M/8).
  - byte_cnt (16-bit) is incremented by popcount(tstrb).
  - The accumulator is written to RAM at wr_ptr when it fills or on tlast; then wr_ptr++.
- pkt_start_ptr latches wr_ptr at the first beat of each frame.
- Overflow:
  - A word write that would make wr_ptr - rd_ptr exceed C_DEPTH_WORDS sets the drop flag.
  - The rest of the frame is accepted and discarded.
- At the tlast beat, the frame resolves as follows:
  - Drop flag set, or meta FIFO full: wr_ptr = pkt_start_ptr; stat_ovf_pkts++.
  - Otherwise terr=1: wr_ptr = pkt_start_ptr; stat_bad_pkts++.
  - Otherwise: push byte_cnt to the meta FIFO; commit wr_ptr; stat_good_pkts++.
  - Overflow takes priority over terr.
- A frame totalling 0 bytes (tlast with tstrb=0 as its only beat) is discarded silently; no counter changes.
- Pointers are log2(C_DEPTH_WORDS)+1 bits with natural wrap; full/empty are decided by MSB compare.
- Read FSM:
  - IDLE: when the meta FIFO is non-empty, pop len, issue a RAM read and go to HEAD.
  - HEAD: present the first word.
    - tuser[15:0] = len, [23:16] = C_DEFAULT_SRC_PORT, [31:24] = C_DEFAULT_DST_PORT, upper bits 0.
    - On tvalid&tready, go to BODY, or to IDLE if this was the last word.
  - BODY: subsequent words, with tuser = 0.
  - tlast is asserted on word ceil(len/(C_M/8)).
  - tstrb is all ones, except the last word, which has (len mod C_M/8) low bytes set (all ones if 0).
- Output is registered; data, tstrb, tuser and tlast stay stable while tvalid & !tready.
- rd_ptr advances on each handshake; released space is visible to the write side on the next cycle.
- Latency: first m_axis_tvalid comes 3 cycles after the good tlast beat is accepted (meta write, RAM read, output register).
- Back-to-back packets: IDLE may be bypassed, giving no bubble when the next meta entry is ready.
- Simultaneous RAM write and read in the same cycle are legal.
- A rewind never moves wr_ptr below the committed pointer.

Decomposition:
- Package nf10_axis_pkg holds:
  - tuser field offsets (TUSER_LEN_LO=0, TUSER_SRC_LO=16, TUSER_DST_LO=24, field widths).
  - A clog2 function.
  - The read FSM state encoding (IDLE/HEAD/BODY).
- Sub-module nf10_sdp_ram: simple dual-port, one write port and one registered-read port, parameterised on width and depth. It holds the data FIFO.
- The meta FIFO is a small register array kept inside the top-level module.

Test Plan:
1. 64-byte frame, bytes 0x00..0x3F, 8-bit input, tready=1.
   -> 8 output words; word0 tdata=64'h0706050403020100; tuser[31:0]=32'h0001_0040; last tstrb=8'hFF; tlast on word 8; stat_good_pkts=1.
2. 61-byte frame.
   -> 8 words; last tstrb=8'h1F; tuser[15:0]=61.
3. 64-byte frame with terr=1, followed by a good 60-byte frame.
   -> only the 60-byte packet appears, intact; stat_bad_pkts=1; stat_good_pkts=1.
4. C_DEPTH_WORDS=16, m_axis_tready=0, 200-byte frame.
   -> no output; stat_ovf_pkts=1. Then release tready and send a 64-byte frame -> it passes correctly.
5. m_axis_tready toggling 1010..., three back-to-back 64-byte frames.
   -> 24 words in order; no duplicated or lost beats; outputs stable during stalls.
6. reset asserted mid-frame at byte 30, then released, then a 64-byte frame.
   -> all outputs and counters are 0 during reset; after release only the new frame is output; stat_good_pkts=1.
